// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_pkg
// Brief    : State, opcode, error-code and flag-index constants for fpu_seq.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_seq_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    localparam logic [2:0] c_op_add  = 3'd0;
    localparam logic [2:0] c_op_mul  = 3'd1;
    localparam logic [2:0] c_op_div  = 3'd2;
    localparam logic [2:0] c_op_sqrt = 3'd3;
    localparam logic [2:0] c_op_cmp  = 3'd4;
    localparam logic [2:0] c_op_max  = 3'd4;

    localparam logic [1:0] c_err_ok  = 2'd0;
    localparam logic [1:0] c_err_ill = 2'd1;
    localparam logic [1:0] c_err_to  = 2'd2;

    // Bit positions inside fpu_flags {ov,un,inv,inexact,div_zero,eq,less,great}
    localparam int c_flg_ov    = 7;
    localparam int c_flg_un    = 6;
    localparam int c_flg_inv   = 5;
    localparam int c_flg_inx   = 4;
    localparam int c_flg_dz    = 3;
    localparam int c_flg_eq    = 2;
    localparam int c_flg_less  = 1;
    localparam int c_flg_great = 0;

endpackage
`default_nettype wire

// File: rtl/fpu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_if
// Brief    : Command/response handshake bundle between requester and fpu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_seq_if #(
    parameter int ADDR_W = 5
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_src2;
    logic [ADDR_W-1:0] cmd_dst;
    logic [2:0]        cmd_rm;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_flags;
    logic [1:0]        rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_rm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_flags, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst, cmd_rm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_flags, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/fpu_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq_timer
// Brief    : Free-running up-counter with synchronous clear and terminal flag.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_seq_timer #(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic [CNT_W-1:0] i_last,
    output logic                  o_tc
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tc = (r_cnt == i_last);
endmodule
`default_nettype wire

// File: rtl/fpu_seq.sv
`default_nettype none
// ============================================================================
// Module   : fpu_seq
// Brief    : One-at-a-time command sequencer driving the single-precision FPU.
//            Optional FPU_SEQ_STICKY_EN adds sticky exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_seq
    import fpu_seq_pkg::*;
#(
    parameter int LOAD_CYC = 2,
    parameter int TIMEOUT  = 15,
    parameter int ADDR_W   = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    fpu_seq_if.slave               bus,
    output logic                   fpu_ld,
    output logic                   fpu_enable,
    output logic [2:0]             fpu_opcode,
    output logic [ADDR_W-1:0]      fpu_addr1,
    output logic [ADDR_W-1:0]      fpu_addr2,
    output logic [ADDR_W-1:0]      fpu_addr3,
    output logic [2:0]             fpu_rm,
    input  wire logic              fpu_done,
    input  wire logic [7:0]        fpu_flags,
`ifdef FPU_SEQ_STICKY_EN
    input  wire logic              sticky_clr,
    output logic [4:0]             sticky_flags,
`endif
    output logic                   busy
);
    localparam logic [7:0] c_load_last = 8'(LOAD_CYC - 1);
    localparam logic [7:0] c_exec_last = 8'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic              r_cmd_ready, r_rsp_valid, r_busy, r_ld, r_en;
    logic [7:0]        r_rsp_flags;
    logic [1:0]        r_rsp_err;
    logic [2:0]        r_opcode, r_rm;
    logic [ADDR_W-1:0] r_addr1, r_addr2, r_addr3;
    logic              w_tc, w_clr;
    logic [7:0]        w_last;

    // Counter restarts on every LOAD and EXEC entry; it only runs inside them.
    assign w_last = (r_state == c_st_load) ? c_load_last : c_exec_last;
    assign w_clr  = !((r_state == c_st_exec) || (r_state == c_st_load && !w_tc));

    fpu_seq_timer #(.CNT_W(8)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_last (w_last),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_flags <= '0;
            r_rsp_err   <= c_err_ok;
            r_busy      <= 1'b0;
            r_ld        <= 1'b0;
            r_en        <= 1'b0;
            r_opcode    <= '0;
            r_rm        <= '0;
            r_addr1     <= '0;
            r_addr2     <= '0;
            r_addr3     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_op > c_op_max) begin
                            // Illegal opcode answers directly; FPU pins stay untouched.
                            r_state     <= c_st_resp;
                            r_rsp_valid <= 1'b1;
                            r_rsp_flags <= '0;
                            r_rsp_err   <= c_err_ill;
                        end else begin
                            r_state  <= c_st_load;
                            r_ld     <= 1'b1;
                            r_en     <= 1'b1;
                            r_opcode <= bus.cmd_op;
                            r_rm     <= bus.cmd_rm;
                            r_addr1  <= bus.cmd_src1;
                            r_addr2  <= bus.cmd_src2;
                            r_addr3  <= bus.cmd_dst;
                        end
                    end
                end
                c_st_load: begin
                    if (w_tc) begin
                        r_state <= c_st_exec;
                        r_ld    <= 1'b0;
                    end
                end
                c_st_exec: begin
                    if (fpu_done) begin
                        r_state     <= c_st_resp;
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_flags <= fpu_flags;
                        r_rsp_err   <= c_err_ok;
                    end else if (w_tc) begin
                        r_state     <= c_st_resp;
                        r_en        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_flags <= '0;
                        r_rsp_err   <= c_err_to;
                    end
                end
                c_st_resp: begin
                    if (bus.rsp_ready) begin
                        r_state     <= c_st_idle;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

`ifdef FPU_SEQ_STICKY_EN
    logic [4:0] r_sticky;

    // Clear has priority over a capture landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst || sticky_clr) begin
            r_sticky <= '0;
        end else if (r_state == c_st_exec && fpu_done) begin
            r_sticky <= r_sticky | fpu_flags[c_flg_ov:c_flg_dz];
        end
    end

    assign sticky_flags = r_sticky;
`endif

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_flags = r_rsp_flags;
    assign bus.rsp_err   = r_rsp_err;
    assign busy          = r_busy;
    assign fpu_ld        = r_ld;
    assign fpu_enable    = r_en;
    assign fpu_opcode    = r_opcode;
    assign fpu_rm        = r_rm;
    assign fpu_addr1     = r_addr1;
    assign fpu_addr2     = r_addr2;
    assign fpu_addr3     = r_addr3;
endmodule
`default_nettype wire
